// File: rtl/qm_truth_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper and its CRC step.
package qm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } qm_state_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam int          QM_N_IN  = 11;
    localparam int          QM_CNT_W = 12;

endpackage

// File: rtl/qm_truth_sweeper_crc16.sv
// One serial, MSB-first CRC-16 step: next signature from the current signature and one bit.
module crc16_serial
    import qm_pkg::*;
(
    input  logic [15:0] i_sig,
    input  logic        i_bit,
    output logic [15:0] o_sig
);

    logic w_fb;

    assign w_fb  = i_sig[15] ^ i_bit;
    assign o_sig = {i_sig[14:0], 1'b0} ^ (w_fb ? CRC_POLY : 16'h0000);

endmodule

// File: rtl/qm_truth_sweeper.sv
// Sweeps every input vector of an N_IN-input combinational function, compacts the
// sampled outputs into a CRC-16 signature and a minterm count, and flags pass/fail.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for start after reset
// ST_HOLD   | current vector driven, waiting SETTLE cycles for it to settle
// ST_SAMPLE | one cycle: fold func_out into signature/count, advance vector
// ST_DONE   | sweep finished, done/pass held until the next start
module qm_truth_sweeper
    import qm_pkg::*;
#(
    parameter int          N_IN      = QM_N_IN,
    parameter int          SETTLE    = 1,
    parameter logic [15:0] EXP_SIG   = 16'h0000,
    parameter logic [11:0] EXP_COUNT = 12'd0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_func_out,
    output logic [N_IN-1:0] o_vec,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_pass,
    output logic [15:0]     o_signature,
    output logic [11:0]     o_minterm_count
);

    localparam int              SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [N_IN-1:0] VEC_LAST    = '1;

    qm_state_t r_state;
    qm_state_t w_state_next;

    logic [SW-1:0]   r_settle;
    logic [N_IN-1:0] r_vec;
    logic [15:0]     r_sig;
    logic [11:0]     r_cnt;
    logic            r_done;
    logic            r_pass;

    logic [15:0]     w_sig_next;
    logic [11:0]     w_cnt_next;
    logic            w_settle_last;
    logic            w_vec_last;

    crc16_serial u_crc (
        .i_sig (r_sig),
        .i_bit (i_func_out),
        .o_sig (w_sig_next)
    );

    assign w_cnt_next    = r_cnt + {11'd0, i_func_out};
    assign w_settle_last = (r_settle == SETTLE_LAST);
    assign w_vec_last    = (r_vec == VEC_LAST);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; start is only honoured when no sweep is running.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (i_start)       w_state_next = ST_HOLD;
            ST_HOLD:          if (w_settle_last) w_state_next = ST_SAMPLE;
            ST_SAMPLE:        w_state_next = w_vec_last ? ST_DONE : ST_HOLD;
            default:          w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: settle timer, vector counter, signature, minterm count and verdict.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_settle <= '0;
            r_vec    <= '0;
            r_sig    <= CRC_INIT;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_settle <= '0;
                        r_vec    <= '0;
                        r_sig    <= CRC_INIT;
                        r_cnt    <= '0;
                        r_done   <= 1'b0;
                        r_pass   <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    r_settle <= r_settle + 1'b1;
                end
                ST_SAMPLE: begin
                    r_sig <= w_sig_next;
                    r_cnt <= w_cnt_next;
                    if (w_vec_last) begin
                        // Verdict uses the values being registered on this same edge.
                        r_done <= 1'b1;
                        r_pass <= (w_sig_next == EXP_SIG) && (w_cnt_next == EXP_COUNT);
                    end else begin
                        r_vec    <= r_vec + 1'b1;
                        r_settle <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_vec           = r_vec;
    assign o_busy          = (r_state == ST_HOLD) || (r_state == ST_SAMPLE);
    assign o_done          = r_done;
    assign o_pass          = r_pass;
    assign o_signature     = r_sig;
    assign o_minterm_count = r_cnt;

endmodule

// File: tb/tb_qm_truth_sweeper.sv
// Bench for qm_truth_sweeper: truth tables held in an array, results checked
// against a straight-line reference built from the sweep rules.
module tb_qm_truth_sweeper;

    localparam int NV = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, start3, mode_delay;
    logic        fo, fo3;
    logic [10:0] vec, vec3;
    logic        busy, done, pass, busy3, done3, pass3;
    logic [15:0] sig, sig3;
    logic [11:0] cnt, cnt3;

    logic tt [0:NV-1];
    logic d1, d2, e1, e2;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_sig;
    int          m_cnt;
    int          bc;
    bit          ok, got;
    int          fidx;

    qm_truth_sweeper #(.SETTLE(1), .EXP_SIG(16'h0000), .EXP_COUNT(12'd1024)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_func_out(fo),
        .o_vec(vec), .o_busy(busy), .o_done(done), .o_pass(pass),
        .o_signature(sig), .o_minterm_count(cnt)
    );

    qm_truth_sweeper #(.SETTLE(3), .EXP_SIG(16'h0000), .EXP_COUNT(12'd1024)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start3), .i_func_out(fo3),
        .o_vec(vec3), .o_busy(busy3), .o_done(done3), .o_pass(pass3),
        .o_signature(sig3), .o_minterm_count(cnt3)
    );

    // Function under test with an optional two-cycle registered delay.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1 <= 1'b0; d2 <= 1'b0; e1 <= 1'b0; e2 <= 1'b0;
        end else begin
            d1 <= tt[vec];  d2 <= d1;
            e1 <= tt[vec3]; e2 <= e1;
        end
    end
    assign fo  = mode_delay ? d2 : tt[vec];
    assign fo3 = e2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: bits seen by the sweeper, folded with the CRC rule and counted.
    task automatic model(input bit delayed, output logic [15:0] s, output int c);
        logic b, fb;
        s = 16'hFFFF;
        c = 0;
        for (int v = 0; v < NV; v++) begin
            b  = delayed ? tt[(v == 0) ? 0 : v - 1] : tt[v];
            c += int'(b);
            fb = s[15] ^ b;
            s  = {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
    endtask

    // Random table with 1024 minterms whose last 16 bits cancel the CRC to zero.
    task automatic craft(output bit found);
        logic [15:0] s;
        logic        fb, tmp;
        int          t, j;
        found = 0;
        for (int a = 0; a < 400 && !found; a++) begin
            for (int i = 0; i < 2032; i++) tt[i] = (i < 1016);
            for (int i = 2031; i > 0; i--) begin
                j = $urandom_range(i, 0);
                tmp = tt[i]; tt[i] = tt[j]; tt[j] = tmp;
            end
            s = 16'hFFFF;
            for (int i = 0; i < 2032; i++) begin
                fb = s[15] ^ tt[i];
                s  = {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
            t = 0;
            for (int k = 0; k < 16; k++) begin
                tt[2032 + k] = s[15 - k];
                t += int'(s[15 - k]);
            end
            if (1016 + t == 1024) found = 1;
        end
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_vec"}, 32'(vec), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_pass"}, 32'(pass), 0);
        chk({tag, "_sig"}, 32'(sig), 32'hFFFF);
        chk({tag, "_cnt"}, 32'(cnt), 0);
    endtask

    // One sweep on the SETTLE=1 instance; optional ignored start pulse and mid-sweep reset.
    task automatic sweep(input string tag, input int pulse_at, input int reset_at,
                         input bit run_chk, output int busy_cycles);
        int  last, exp_run;
        bit  pulsed, fin;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({tag, "_busy_rise"}, 32'(busy), 1);
        chk({tag, "_vec_first"}, 32'(vec), 0);
        busy_cycles = 1; last = 0; exp_run = 0; pulsed = 0; fin = 0;
        for (int k = 0; k < 10000 && !fin; k++) begin
            if (pulse_at >= 0 && int'(vec) == pulse_at && !pulsed) begin
                start = 1'b1; pulsed = 1;
            end else begin
                start = 1'b0;
            end
            if (reset_at >= 0 && int'(vec) == reset_at) begin
                rst_n = 1'b0;
                #1;
                reset_vals({tag, "_midrst"});
                @(negedge clk); rst_n = 1'b1;
                return;
            end
            @(negedge clk);
            if (done) begin
                fin = 1;
            end else begin
                if (busy) busy_cycles++;
                if (int'(vec) != last) begin
                    chk({tag, "_vec_order"}, 32'(vec), 32'(last + 1));
                    if (run_chk) begin
                        exp_run += int'(tt[last]);
                        chk({tag, "_run_cnt"}, 32'(cnt), 32'(exp_run));
                    end
                    last = int'(vec);
                end
            end
        end
        start = 1'b0;
        chk({tag, "_timeout"}, 32'(fin), 1);
    endtask

    task automatic end_check(input string tag, input bit delayed, input int busy_cycles);
        model(delayed, m_sig, m_cnt);
        chk({tag, "_cycles"}, 32'(busy_cycles), 4096);
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_vec_end"}, 32'(vec), 2047);
        chk({tag, "_cnt"}, 32'(cnt), 32'(m_cnt));
        chk({tag, "_sig"}, 32'(sig), 32'(m_sig));
        chk({tag, "_pass"}, 32'(pass), 32'((m_sig == 16'h0000) && (m_cnt == 1024)));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start3 = 1'b0; mode_delay = 1'b0;
        for (int i = 0; i < NV; i++) tt[i] = 1'b0;
        repeat (3) @(negedge clk);
        reset_vals("reset");
        rst_n = 1'b1;

        // Constant 0
        sweep("zero", -1, -1, 1, bc);
        end_check("zero", 0, bc);
        @(negedge clk);
        chk("zero_done_level", 32'(done), 1);

        // Constant 1: count reaches 2048 without wrap
        for (int i = 0; i < NV; i++) tt[i] = 1'b1;
        sweep("one", -1, -1, 1, bc);
        end_check("one", 0, bc);
        chk("one_cnt_800", 32'(cnt), 32'h800);

        // func = a (vec[10])
        for (int i = 0; i < NV; i++) tt[i] = (i >= 1024);
        sweep("fa", -1, -1, 1, bc);
        end_check("fa", 0, bc);

        // Crafted lab table, with an ignored start at vector 500
        craft(ok);
        chk("craft_found", 32'(ok), 1);
        sweep("lab", 500, -1, 1, bc);
        end_check("lab", 0, bc);
        chk("lab_pass", 32'(pass), 1);

        // One term flipped
        fidx = $urandom_range(NV - 1, 0);
        tt[fidx] = ~tt[fidx];
        sweep("flip", -1, -1, 1, bc);
        end_check("flip", 0, bc);
        chk("flip_pass", 32'(pass), 0);
        tt[fidx] = ~tt[fidx];

        // Reset at vector 1000, then a clean sweep from 0
        sweep("abort", -1, 1000, 1, bc);
        sweep("after", -1, -1, 1, bc);
        end_check("after", 0, bc);

        // Delayed function: SETTLE=1 samples a stale bit
        rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
        mode_delay = 1'b1;
        repeat (2) @(negedge clk);
        sweep("dly1", -1, -1, 0, bc);
        end_check("dly1", 1, bc);
        mode_delay = 1'b0;

        // Delayed function: SETTLE=3 instance absorbs the latency
        @(negedge clk); start3 = 1'b1;
        @(negedge clk); start3 = 1'b0;
        chk("s3_busy_rise", 32'(busy3), 1);
        bc = 1; got = 0;
        for (int k = 0; k < 20000 && !got; k++) begin
            @(negedge clk);
            if (done3) got = 1;
            else if (busy3) bc++;
        end
        chk("s3_timeout", 32'(got), 1);
        model(0, m_sig, m_cnt);
        chk("s3_cycles", 32'(bc), 8192);
        chk("s3_cnt", 32'(cnt3), 32'(m_cnt));
        chk("s3_sig", 32'(sig3), 32'(m_sig));
        chk("s3_pass", 32'(pass3), 1);

        // Start held high: done lasts one cycle, new sweep restarts at 0
        @(negedge clk); start = 1'b1;
        got = 0;
        for (int k = 0; k < 10000 && !got; k++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        chk("hold_timeout", 32'(got), 1);
        chk("hold_pass", 32'(pass), 1);
        @(negedge clk);
        chk("hold_done_1cyc", 32'(done), 0);
        chk("hold_busy", 32'(busy), 1);
        chk("hold_vec0", 32'(vec), 0);
        start = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
